// File: rtl/envelope_follower.sv
// Purpose : per-channel peak envelope follower (rectify + asymmetric one-pole smoothing) over N_FILTERS lanes.
// Latency : one pass takes 2*N_FILTERS+2 edges, counting the accepting edge as the first; valid_out comes on the last.
// Backpr. : none; valid_in is accepted only in IDLE, and strobes during a pass are dropped.
//
// Build option: define ENV_ACTIVE_MASK_EN to add the active_mask output.
//
// Ports:
//   clk_in            rising-edge clock
//   rst_in            asynchronous active-high reset
//   valid_in          one-cycle strobe, filtered_channels holds a new sample set
//   attack_shift      smoothing shift used while rectified input exceeds the envelope
//   release_shift     smoothing shift used otherwise
//   filtered_channels lane i in bits [32*i+31:32*i], two's complement
//   envelope_channels published (gated) envelopes, same lane packing
//   valid_out         one-cycle pulse, envelope_channels just updated
//   busy              high whenever a pass is in progress
//   active_mask       (ENV_ACTIVE_MASK_EN only) per-lane envelope-above-floor flags

package envelope_follower_pkg;
    localparam int N_FILTERS = 4;
endpackage

module envelope_follower
    import envelope_follower_pkg::*;
#(
    parameter logic signed [31:0] GATE_FLOOR = 32'sd0
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      valid_in,
    input  logic [4:0]                attack_shift,
    input  logic [4:0]                release_shift,
    input  logic [32*N_FILTERS-1:0]   filtered_channels,
    output logic [32*N_FILTERS-1:0]   envelope_channels,
    output logic                      valid_out,
    output logic                      busy
`ifdef ENV_ACTIVE_MASK_EN
    ,
    output logic [N_FILTERS-1:0]      active_mask
`endif
);

    localparam int IDX_W = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECTIFY = 2'd1,
        UPDATE  = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [31:0]       snap_q    [N_FILTERS];
    logic signed [31:0]       snap_d    [N_FILTERS];
    logic signed [31:0]       env_q     [N_FILTERS];
    logic signed [31:0]       env_d     [N_FILTERS];
    logic signed [31:0]       env_out_q [N_FILTERS];
    logic signed [31:0]       env_out_d [N_FILTERS];
    logic [4:0]               atk_q, atk_d;
    logic [4:0]               rel_q, rel_d;
    logic signed [31:0]       rect_q, rect_d;
    logic                     valid_q, valid_d;
`ifdef ENV_ACTIVE_MASK_EN
    logic [N_FILTERS-1:0]     mask_q, mask_d;
`endif

    // datapath for the lane currently selected by idx_q
    logic signed [31:0]       cur_snap;
    logic signed [31:0]       cur_env;
    logic signed [31:0]       rect_abs;
    logic [4:0]               shift_sel;
    logic signed [32:0]       diff;
    logic signed [32:0]       step;
    logic [31:0]              env_next;

    always_comb begin
        cur_snap = snap_q[idx_q];
        cur_env  = env_q[idx_q];

        // |x| of the most negative value does not fit; clamp it to the largest positive
        if (cur_snap == 32'sh8000_0000) begin
            rect_abs = 32'sh7fff_ffff;
        end else if (cur_snap < 0) begin
            rect_abs = -cur_snap;
        end else begin
            rect_abs = cur_snap;
        end

        shift_sel = (rect_q > cur_env) ? atk_q : rel_q;

        // Both operands are non-negative, so the 33-bit difference cannot overflow.
        // Arithmetic shift floors toward -inf, so a falling envelope lands on rect
        // at worst and never below it; a rising one never passes rect.
        diff     = {rect_q[31], rect_q} - {cur_env[31], cur_env};
        step     = diff >>> shift_sel;
        env_next = cur_env + step[31:0];
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        env_d     = env_q;
        env_out_d = env_out_q;
        atk_d     = atk_q;
        rel_d     = rel_q;
        rect_d    = rect_q;
        valid_d   = 1'b0;
`ifdef ENV_ACTIVE_MASK_EN
        mask_d    = mask_q;
`endif

        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    for (int i = 0; i < N_FILTERS; i++) begin
                        snap_d[i] = filtered_channels[32*i +: 32];
                    end
                    atk_d   = attack_shift;
                    rel_d   = release_shift;
                    idx_d   = '0;
                    state_d = RECTIFY;
                end
            end
            RECTIFY: begin
                rect_d  = rect_abs;
                state_d = UPDATE;
            end
            UPDATE: begin
                env_d[idx_q] = env_next;
                if (idx_q == IDX_W'(N_FILTERS - 1)) begin
                    state_d = PUBLISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RECTIFY;
                end
            end
            PUBLISH: begin
                // gate only what leaves the block; env itself keeps tracking below the floor
                for (int i = 0; i < N_FILTERS; i++) begin
                    env_out_d[i] = (env_q[i] > GATE_FLOOR) ? env_q[i] : 32'sd0;
`ifdef ENV_ACTIVE_MASK_EN
                    mask_d[i]    = (env_q[i] > GATE_FLOOR);
`endif
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            atk_q   <= '0;
            rel_q   <= '0;
            rect_q  <= '0;
            valid_q <= 1'b0;
            for (int i = 0; i < N_FILTERS; i++) begin
                snap_q[i]    <= '0;
                env_q[i]     <= '0;
                env_out_q[i] <= '0;
            end
`ifdef ENV_ACTIVE_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            atk_q   <= atk_d;
            rel_q   <= rel_d;
            rect_q  <= rect_d;
            valid_q <= valid_d;
            for (int i = 0; i < N_FILTERS; i++) begin
                snap_q[i]    <= snap_d[i];
                env_q[i]     <= env_d[i];
                env_out_q[i] <= env_out_d[i];
            end
`ifdef ENV_ACTIVE_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    always_comb begin
        envelope_channels = '0;
        for (int i = 0; i < N_FILTERS; i++) begin
            envelope_channels[32*i +: 32] = env_out_q[i];
        end
    end

    assign valid_out = valid_q;
    assign busy      = (state_q != IDLE);
`ifdef ENV_ACTIVE_MASK_EN
    assign active_mask = mask_q;
`endif

endmodule

// File: tb/tb_envelope_follower.sv
// Purpose : randomized + directed check of envelope_follower against an arithmetic reference model.
// Latency : expects valid_out on the (2*N+2)-th edge counting the accepting edge as the first.
// Backpr. : n/a; drives strobes back to back at minimum spacing and injects ignored mid-pass strobes.

module tb_envelope_follower;
    import envelope_follower_pkg::*;

    localparam int     N      = N_FILTERS;
    localparam int     LAT    = 2 * N + 2;
    localparam longint FLOOR1 = 16384;

    logic               clk_in = 1'b0;
    logic               rst_in;
    logic               valid_in;
    logic [4:0]         attack_shift;
    logic [4:0]         release_shift;
    logic [32*N-1:0]    filtered_channels;
    logic [32*N-1:0]    env0, env1;
    logic               vo0, vo1, busy0, busy1;
`ifdef ENV_ACTIVE_MASK_EN
    logic [N-1:0]       mask0, mask1;
`endif

    always #5 clk_in = ~clk_in;

    envelope_follower u_dut0 (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .valid_in          (valid_in),
        .attack_shift      (attack_shift),
        .release_shift     (release_shift),
        .filtered_channels (filtered_channels),
        .envelope_channels (env0),
        .valid_out         (vo0),
        .busy              (busy0)
`ifdef ENV_ACTIVE_MASK_EN
        ,
        .active_mask       (mask0)
`endif
    );

    envelope_follower #(.GATE_FLOOR(32'sd16384)) u_dut1 (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .valid_in          (valid_in),
        .attack_shift      (attack_shift),
        .release_shift     (release_shift),
        .filtered_channels (filtered_channels),
        .envelope_channels (env1),
        .valid_out         (vo1),
        .busy              (busy1)
`ifdef ENV_ACTIVE_MASK_EN
        ,
        .active_mask       (mask1)
`endif
    );

    int     n_tot = 0;
    int     n_bad = 0;
    longint env_m  [N];
    longint stim_x [N];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input logic [32*N-1:0] bus, input int i);
        return longint'($signed(bus[32*i +: 32]));
    endfunction

    function automatic longint rect_of(input longint v);
        longint a;
        a = (v < 0) ? -v : v;
        if (a > 64'sd2147483647) a = 64'sd2147483647;
        return a;
    endfunction

    // floor(d / 2^s) in plain integer arithmetic
    function automatic longint floor_div_pow2(input longint d, input int s);
        longint p;
        p = 1;
        for (int k = 0; k < s; k++) p = p * 2;
        if (d >= 0) return d / p;
        return -((-d + p - 1) / p);
    endfunction

    function automatic longint gated(input longint e, input longint f);
        return (e > f) ? e : 0;
    endfunction

    task automatic check_outputs(input string pfx);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_env0[%0d]", pfx, i), lane(env0, i), gated(env_m[i], 0));
            chk($sformatf("%s_env1[%0d]", pfx, i), lane(env1, i), gated(env_m[i], FLOOR1));
`ifdef ENV_ACTIVE_MASK_EN
            chk($sformatf("%s_mask0[%0d]", pfx, i), longint'(mask0[i]), longint'(env_m[i] > 0));
            chk($sformatf("%s_mask1[%0d]", pfx, i), longint'(mask1[i]), longint'(env_m[i] > FLOOR1));
`endif
        end
    endtask

    // entered and left at a negedge
    task automatic do_reset();
        rst_in   = 1'b1;
        valid_in = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        for (int i = 0; i < N; i++) env_m[i] = 0;
        chk("rst_vo0", longint'(vo0), 0);
        chk("rst_vo1", longint'(vo1), 0);
        chk("rst_busy0", longint'(busy0), 0);
        chk("rst_busy1", longint'(busy1), 0);
        check_outputs("rst");
        rst_in = 1'b0;
    endtask

    // counts valid_out pulses over a quiet window
    task automatic watch_quiet(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (vo0 || vo1) cnt++;
        end
    endtask

    // one full pass using stim_x; spur_at > 0 injects a stray strobe on that cycle
    task automatic do_pass(input int atk, input int rel, input int spur_at);
        int got;
        int k;
        longint r;
        int s;
        check_outputs("hold");
        for (int i = 0; i < N; i++) filtered_channels[32*i +: 32] = stim_x[i][31:0];
        attack_shift  = 5'(atk);
        release_shift = 5'(rel);
        valid_in      = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in          = 1'b0;
        filtered_channels = {N{$urandom}};
        attack_shift      = 5'($urandom);
        release_shift     = 5'($urandom);
        chk("pulse_low", longint'(vo0), 0);
        chk("busy0_run", longint'(busy0), 1);
        chk("busy1_run", longint'(busy1), 1);

        for (int i = 0; i < N; i++) begin
            r = rect_of(stim_x[i]);
            s = (r > env_m[i]) ? atk : rel;
            env_m[i] = env_m[i] + floor_div_pow2(r - env_m[i], s);
        end

        got = 0;
        k   = 1;
        while (got == 0 && k < LAT + 6) begin
            @(posedge clk_in);
            k++;
            @(negedge clk_in);
            valid_in = (k == spur_at);
            if (valid_in) filtered_channels = {N{$urandom}};
            if (vo0) got = k;
        end
        valid_in = 1'b0;
        chk("latency", longint'(got), longint'(LAT));
        chk("vo1", longint'(vo1), 1);
        chk("busy0_done", longint'(busy0), 0);
        check_outputs("pub");
    endtask

    function automatic longint rand_sample();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return -64'sd2147483648;
            2:       return longint'($urandom_range(0, 20000));
            3:       return -longint'($urandom_range(0, 20000));
            4:       return longint'($signed($urandom));
            default: return 64'sd2147483647;
        endcase
    endfunction

    initial begin
        int cnt;
        rst_in            = 1'b1;
        valid_in          = 1'b0;
        attack_shift      = '0;
        release_shift     = '0;
        filtered_channels = '0;
        for (int i = 0; i < N; i++) env_m[i] = 0;
        @(negedge clk_in);
        do_reset();

        // all lanes 1000, shift 0
        for (int i = 0; i < N; i++) stim_x[i] = 1000;
        do_pass(0, 0, 0);
        for (int i = 0; i < N; i++) chk("lvl1000", lane(env0, i), 1000);

        // attack 1 from zero on a negative input
        do_reset();
        for (int i = 0; i < N; i++) stim_x[i] = 3000 * i;
        stim_x[0] = -1000;
        do_pass(1, 4, 0);
        chk("atk_p1", lane(env0, 0), 500);
        do_pass(1, 4, 0);
        chk("atk_p2", lane(env0, 0), 750);
        do_pass(1, 4, 0);
        chk("atk_p3", lane(env0, 0), 875);

        // release decay from 1024, then most-negative saturation
        do_reset();
        for (int i = 0; i < N; i++) stim_x[i] = 1024;
        do_pass(0, 0, 0);
        for (int i = 0; i < N; i++) stim_x[i] = 0;
        do_pass(2, 2, 0);
        chk("rel_p1", lane(env0, 0), 768);
        do_pass(2, 2, 0);
        chk("rel_p2", lane(env0, 0), 576);
        stim_x[1] = -64'sd2147483648;
        do_pass(0, 0, 0);
        chk("sat_min", lane(env0, 1), 2147483647);

        // gate floor affects published value only
        do_reset();
        for (int i = 0; i < N; i++) stim_x[i] = 16000;
        do_pass(0, 0, 0);
        chk("gate_below", lane(env1, 0), 0);
        chk("gate_ungated", lane(env0, 0), 16000);
        for (int i = 0; i < N; i++) stim_x[i] = 17000;
        do_pass(1, 1, 0);
        chk("gate_internal", lane(env1, 0), 16500);
        for (int i = 0; i < N; i++) stim_x[i] = 20000;
        do_pass(0, 0, 0);
        chk("gate_above", lane(env1, 0), 20000);

        // stray strobe 3 cycles into a pass is dropped
        for (int i = 0; i < N; i++) stim_x[i] = 5000 + i;
        do_pass(3, 3, 3);
        watch_quiet(LAT + 4, cnt);
        chk("stray_pulses", longint'(cnt), 0);

        // reset mid-pass: no publish, outputs cleared, next pass from zero
        for (int i = 0; i < N; i++) stim_x[i] = 9000;
        for (int i = 0; i < N; i++) filtered_channels[32*i +: 32] = stim_x[i][31:0];
        valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        do_reset();
        watch_quiet(LAT + 4, cnt);
        chk("abort_pulses", longint'(cnt), 0);
        for (int i = 0; i < N; i++) chk("abort_out0", lane(env0, i), 0);
        do_pass(1, 1, 0);
        chk("restart_env", lane(env0, 0), 4500);

`ifdef ENV_ACTIVE_MASK_EN
        do_reset();
        for (int i = 0; i < N; i++) stim_x[i] = (i % 2 == 1) ? 5000 : 0;
        do_pass(0, 0, 0);
        begin
            logic [N-1:0] exp_mask;
            for (int i = 0; i < N; i++) exp_mask[i] = (i % 2 == 1);
            chk("mask_alt", longint'(mask0), longint'(exp_mask));
        end
`endif

        // randomized passes at minimum spacing with stray strobes and occasional resets
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) do_reset();
            for (int i = 0; i < N; i++) stim_x[i] = rand_sample();
            do_pass($urandom_range(0, 1) ? $urandom_range(0, 4) : $urandom_range(0, 31),
                    $urandom_range(0, 1) ? $urandom_range(0, 4) : $urandom_range(0, 31),
                    $urandom_range(0, 1) ? $urandom_range(2, LAT - 1) : 0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
